// File: rtl/pacman_sprite_reader.sv
// Pac-Man sprite reader: latches sprite state per frame, fetches one ROM row
// per scanline and shifts it out MSB-first in step with DrawX.
module pacman_sprite_reader #(
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  parameter int unsigned ANIM_PERIOD = 8,
  parameter int unsigned FETCH_LEAD  = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  PacX,
  input  logic [9:0]  PacY,
  input  logic [1:0]  dir,
  input  logic        moving,
  output logic [11:0] rom_addr,
  input  logic [16:0] rom_data,
  output logic        pixel_on
);

  localparam int unsigned AW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned CW = $clog2(SPRITE_W);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  logic [9:0]          pixX_q, pixX_d, pixY_q, pixY_d;
  logic [1:0]          dir_q, dir_d;
  logic                mouth_q, mouth_d;
  logic [AW-1:0]       anim_q, anim_d;
  logic [11:0]         addr_q, addr_d;
  logic [SPRITE_W-1:0] shift_q, shift_d;
  logic [CW-1:0]       col_q, col_d;
  state_t              state_q, state_d;

  logic [10:0]   y_ext, top_ext, bot_ext;
  logic [9:0]    row_diff;
  logic [RW-1:0] row;
  logic          row_hit;
  logic [2:0]    idx;
  logic          unused_bits;

  always_comb begin
    pixX_d  = pixX_q;
    pixY_d  = pixY_q;
    dir_d   = dir_q;
    mouth_d = mouth_q;
    anim_d  = anim_q;
    if (frame_start) begin
      pixX_d = PacX;
      pixY_d = PacY;
      dir_d  = dir;
      if (moving) begin
        if (anim_q == AW'(ANIM_PERIOD - 1)) begin
          anim_d  = '0;
          mouth_d = ~mouth_q;
        end else begin
          anim_d = anim_q + 1'b1;
        end
      end
    end
  end

  // 11-bit compare so a sprite near the bottom never wraps into row hits.
  assign y_ext    = {1'b0, DrawY};
  assign top_ext  = {1'b0, pixY_q};
  assign bot_ext  = top_ext + 11'(SPRITE_H);
  assign row_hit  = (y_ext >= top_ext) && (y_ext < bot_ext);
  assign row_diff = DrawY - pixY_q;
  assign row      = row_diff[RW-1:0];
  assign idx      = mouth_q ? (3'd1 + {1'b0, dir_q}) : 3'd0;

  assign unused_bits = ^{rom_data[16], row_diff};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (row_hit && (pixX_q >= 10'(FETCH_LEAD)) &&
            (DrawX == pixX_q - 10'(FETCH_LEAD))) begin
          addr_d  = 12'(idx) * 12'(SPRITE_H) + 12'(row);
          state_d = FETCH;
        end
      end
      FETCH: begin
        shift_d = rom_data[SPRITE_W-1:0];
        col_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (col_q == CW'(SPRITE_W - 1)) begin
          shift_d = '0;
          state_d = IDLE;
        end else begin
          shift_d = shift_q << 1;
          col_d   = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixX_q  <= '0;
      pixY_q  <= '0;
      dir_q   <= 2'd3;
      mouth_q <= 1'b0;
      anim_q  <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      col_q   <= '0;
      state_q <= IDLE;
    end else begin
      pixX_q  <= pixX_d;
      pixY_q  <= pixY_d;
      dir_q   <= dir_d;
      mouth_q <= mouth_d;
      anim_q  <= anim_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      col_q   <= col_d;
      state_q <= state_d;
    end
  end

  assign rom_addr = addr_q;
  assign pixel_on = (state_q == SHIFT) & shift_q[SPRITE_W-1];

endmodule

// File: tb/tb_pacman_sprite_reader.sv
// Directed bench for pacman_sprite_reader: scans lines against a small ROM
// and compares captured pixels and fetch addresses with hand-derived values.
module tb_pacman_sprite_reader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = 10'd500;
  logic [9:0]  PacX = '0, PacY = '0;
  logic [1:0]  dir = 2'd3;
  logic        moving = 1'b0;
  logic [11:0] rom_addr;
  logic [16:0] rom_data;
  logic        pixel_on;

  logic [16:0] rom [0:79];
  logic        px [0:1023];
  logic [11:0] ad [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign rom_data = (rom_addr < 12'd80) ? rom[rom_addr] : 17'h00000;

  pacman_sprite_reader #(
    .SPRITE_W(16), .SPRITE_H(16), .ANIM_PERIOD(8), .FETCH_LEAD(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .PacX(PacX), .PacY(PacY),
    .dir(dir), .moving(moving), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel_on(pixel_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input int x, input int y, input int d, input logic m);
    @(posedge Clk); #1;
    DrawX = '0; DrawY = 10'd500;
    PacX = 10'(x); PacY = 10'(y); dir = 2'(d); moving = m;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  // fs_x: frame_start asserted while DrawX==fs_x (new PacX = fs_px).
  // rst_x: Reset_n pulsed low mid-cycle while DrawX==rst_x.
  task automatic scan(input int y, input int x0, input int x1,
                      input int fs_x, input int fs_px, input int rst_x);
    for (int x = 0; x < 1024; x++) begin
      px[x] = 1'b0;
      ad[x] = '0;
    end
    for (int x = x0; x <= x1; x++) begin
      @(posedge Clk); #1;
      DrawY = 10'(y);
      DrawX = 10'(x);
      frame_start = (x == fs_x);
      if (x == fs_x) PacX = 10'(fs_px);
      if (x == rst_x) begin
        #2 Reset_n = 1'b0;
        #1;
        check("rst_pixel_now", {31'b0, pixel_on}, 32'd0);
        check("rst_addr_now", {20'b0, rom_addr}, 32'd0);
      end
      @(negedge Clk);
      px[x] = pixel_on;
      ad[x] = rom_addr;
      if (x == rst_x) #1 Reset_n = 1'b1;
    end
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int x0);
    logic [15:0] p;
    for (int c = 0; c < 16; c++) p[15-c] = px[x0+c];
    return {16'b0, p};
  endfunction

  function automatic logic [31:0] ones(input int x0, input int x1);
    int n = 0;
    for (int x = x0; x <= x1; x++) n += int'(px[x]);
    return 32'(n);
  endfunction

  initial begin
    for (int i = 0; i < 80; i++) rom[i] = 17'h10000;
    rom[3]  = 17'h107E0;
    rom[5]  = 17'h1FFFF;
    rom[20] = 17'h0C003;
    rom[21] = 17'h1F00F;
    rom[22] = 17'h0FFFF;
    rom[69] = 17'h08001;

    repeat (2) @(posedge Clk);
    #1;
    check("reset_addr", {20'b0, rom_addr}, 32'd0);
    check("reset_pixel", {31'b0, pixel_on}, 32'd0);
    @(negedge Clk) Reset_n = 1'b1;

    // Closed mouth sprite, row 3.
    frame(100, 50, 3, 1'b0);
    scan(53, 90, 130, -1, 0, -1);
    check("closed_addr", {20'b0, ad[99]}, 32'd3);
    check("closed_pat", pat(100), 32'h07E0);
    check("closed_ones", ones(90, 130), 32'd6);

    // Animation: 8 moving frames open the mouth (facing right).
    for (int i = 0; i < 8; i++) frame(100, 50, 3, 1'b1);
    scan(55, 90, 130, -1, 0, -1);
    check("open_right_addr", {20'b0, ad[99]}, 32'd69);
    check("open_right_pat", pat(100), 32'h8001);
    for (int i = 0; i < 8; i++) frame(100, 50, 3, 1'b1);
    scan(55, 90, 130, -1, 0, -1);
    check("reclosed_addr", {20'b0, ad[99]}, 32'd5);
    check("reclosed_pat", pat(100), 32'hFFFF);

    // Mid-frame dir change is ignored until the next frame latch.
    for (int i = 0; i < 8; i++) frame(100, 50, 3, 1'b1);
    scan(52, 90, 130, -1, 0, -1);
    check("open_row2_addr", {20'b0, ad[99]}, 32'd66);
    dir = 2'd0;
    scan(53, 90, 130, -1, 0, -1);
    check("dir_unlatched_addr", {20'b0, ad[99]}, 32'd67);
    frame(100, 50, 0, 1'b0);
    scan(53, 90, 130, -1, 0, -1);
    check("dir_up_addr", {20'b0, ad[99]}, 32'd19);

    // PacX below fetch lead: nothing drawn, address held.
    frame(1, 50, 0, 1'b0);
    scan(53, 0, 40, -1, 0, -1);
    check("pacx1_ones", ones(0, 40), 32'd0);
    check("pacx1_addr_held", {20'b0, ad[20]}, 32'd19);
    frame(2, 50, 0, 1'b0);
    scan(54, 0, 40, -1, 0, -1);
    check("pacx2_addr", {20'b0, ad[1]}, 32'd20);
    check("pacx2_pat", pat(2), 32'hC003);
    check("pacx2_before", {31'b0, px[1]}, 32'd0);
    check("pacx2_ones", ones(0, 40), 32'd4);

    // frame_start on the fetch clock: this line still uses PacX=100.
    frame(100, 50, 0, 1'b0);
    scan(54, 90, 130, 98, 200, -1);
    check("coinc_addr", {20'b0, ad[99]}, 32'd20);
    check("coinc_pat", pat(100), 32'hC003);
    scan(55, 190, 230, -1, 0, -1);
    check("moved_addr", {20'b0, ad[199]}, 32'd21);
    check("moved_pat", pat(200), 32'hF00F);

    // Reset mid-line.
    scan(56, 190, 230, -1, 0, 205);
    check("pre_reset_pixel", {31'b0, px[204]}, 32'd1);
    check("post_reset_ones", ones(205, 230), 32'd0);
    scan(5, 0, 40, -1, 0, -1);
    check("after_reset_ones", ones(0, 40), 32'd0);
    check("after_reset_addr", {20'b0, ad[40]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
